// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants, capture FSM states and colour reduction.
package vga_pkg;

    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_TOTAL  = 800;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_TOTAL  = 525;
    localparam int unsigned VGA_ADDR_W   = 15;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_t;

    // RGB444 {R,G,B} to RGB222 by keeping the two MSBs of each channel.
    function automatic logic [5:0] rgb222(input logic [11:0] d);
        return {d[11:10], d[7:6], d[3:2]};
    endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Linear frame-RAM write port driven by the capture block.
interface vga_capture_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_timing_rx.sv
// Sync edge detection, line/frame counters, lock tracking and timing errors.
module vga_timing_rx
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BACK  = VGA_H_BACK,
    parameter int unsigned H_TOTAL = VGA_H_TOTAL,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BACK  = VGA_V_BACK,
    parameter int unsigned V_TOTAL = VGA_V_TOTAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] data,
    output logic [11:0] pix,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        vs_fall,
    output logic        locked,
    output logic        err
);

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);

    logic        s_hs, s_vs;
    logic [11:0] s_d;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        vpend;
    logic        h_seen, v_seen;
    logic [1:0]  h_run, h_run_n;
    logic        h_ok, h_ok_n, v_ok, v_ok_n;
    logic        hs_fall, vs_fall_c, start_c;
    logic        line_chk, line_bad, frame_chk, frame_bad;

    // Edges compare the stored sample against the one being registered, so the
    // counters already describe s_d in the clk after it is captured.
    always_comb begin
        hs_fall   = pix_en & s_hs & ~hsync;
        vs_fall_c = pix_en & s_vs & ~vsync;
        start_c   = hs_fall & (vpend | vs_fall_c);
        line_chk  = hs_fall & h_seen & (h_cnt != '1);
        line_bad  = line_chk & (h_cnt != H_LAST);
        frame_chk = start_c & v_seen & (v_cnt != '1);
        frame_bad = frame_chk & (v_cnt != V_LAST);
        h_run_n   = h_run;
        h_ok_n    = h_ok;
        v_ok_n    = v_ok;
        if (line_bad) begin
            h_run_n = '0;
            h_ok_n  = 1'b0;
        end else if (line_chk) begin
            h_run_n = (h_run == 2'd2) ? 2'd2 : h_run + 2'd1;
            h_ok_n  = (h_run_n == 2'd2);
        end
        if (frame_bad) begin
            v_ok_n = 1'b0;
        end else if (frame_chk) begin
            v_ok_n = 1'b1;
        end
    end

    // Input sampling, counters and lock state; the first partial line/frame
    // after reset is not length-checked.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_hs        <= 1'b0;
            s_vs        <= 1'b0;
            s_d         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vpend       <= 1'b0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            h_run       <= '0;
            h_ok        <= 1'b0;
            v_ok        <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            frame_start <= 1'b0;
            vs_fall     <= 1'b0;
        end else begin
            if (pix_en) begin
                s_hs <= hsync;
                s_vs <= vsync;
                s_d  <= data;
                if (hs_fall) begin
                    h_cnt  <= '0;
                    h_seen <= 1'b1;
                    if (start_c) begin
                        v_cnt  <= '0;
                        vpend  <= 1'b0;
                        v_seen <= 1'b1;
                    end else if (v_cnt != '1) begin
                        v_cnt <= v_cnt + 10'd1;
                    end
                end else begin
                    if (h_cnt != '1) begin
                        h_cnt <= h_cnt + 11'd1;
                    end
                    if (vs_fall_c) begin
                        vpend <= 1'b1;
                    end
                end
            end
            h_run       <= h_run_n;
            h_ok        <= h_ok_n;
            v_ok        <= v_ok_n;
            locked      <= h_ok_n & v_ok_n;
            err         <= line_bad | frame_bad;
            frame_start <= start_c;
            vs_fall     <= vs_fall_c;
        end
    end

    assign pix = s_d;
    assign x   = h_cnt - H_START;
    assign y   = v_cnt - V_START;

endmodule

// File: rtl/vga_capture.sv
// VGA stream capture: waits for timing lock, then writes one windowed
// RGB222 sub-image per armed frame into a linear frame RAM.
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BACK  = VGA_H_BACK,
    parameter int unsigned H_TOTAL = VGA_H_TOTAL,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BACK  = VGA_V_BACK,
    parameter int unsigned V_TOTAL = VGA_V_TOTAL,
    parameter int unsigned X_OFF   = 0,
    parameter int unsigned Y_OFF   = 0,
    parameter int unsigned IMG_W   = 160,
    parameter int unsigned IMG_H   = 120,
    parameter int unsigned ADDR_W  = VGA_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          VGA_HSYNC,
    input  logic          VGA_VSYNC,
    input  logic [11:0]   VGA_D,
    input  logic          arm,
    vga_capture_if.master wr,
    output logic          locked,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    localparam logic [10:0]       X_LO      = 11'(X_OFF);
    localparam logic [10:0]       X_HI      = 11'(X_OFF + IMG_W);
    localparam logic [9:0]        Y_LO      = 10'(Y_OFF);
    localparam logic [9:0]        Y_HI      = 10'(Y_OFF + IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    cap_state_t        state, state_next;
    logic [11:0]       pix;
    logic [10:0]       x;
    logic [9:0]        y;
    logic              frame_start, vs_fall, t_err;
    logic              pix_d, in_window, do_write, abort;
    logic              abort_err;
    logic [ADDR_W-1:0] cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [5:0]        wr_data_q;

    vga_timing_rx #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_TOTAL(H_TOTAL),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_TOTAL(V_TOTAL)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hsync      (VGA_HSYNC),
        .vsync      (VGA_VSYNC),
        .data       (VGA_D),
        .pix        (pix),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .vs_fall    (vs_fall),
        .locked     (locked),
        .err        (t_err)
    );

    // Negative x/y wrap to large values, so plain unsigned bounds suffice.
    assign in_window = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

    // Capture state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and write/abort decisions.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (frame_start && locked) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!locked || vs_fall) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (pix_d && in_window) begin
                    do_write = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write port, address counter and status pulses; an abort caused by lock
    // loss already reports err through the timing block, so it is not repeated.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_d      <= 1'b0;
            cnt        <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_done <= 1'b0;
            abort_err  <= 1'b0;
        end else begin
            pix_d      <= pix_en;
            wr_en_q    <= do_write;
            frame_done <= (state == DONE);
            abort_err  <= abort & ~t_err;
            if (abort) begin
                cnt <= '0;
            end else if (do_write) begin
                wr_addr_q <= cnt;
                wr_data_q <= rgb222(pix);
                cnt       <= (cnt == LAST_ADDR) ? '0 : cnt + ADDR_W'(1);
            end
        end
    end

    assign wr.wr_en   = wr_en_q;
    assign wr.wr_addr = wr_addr_q;
    assign wr.wr_data = wr_data_q;
    assign busy       = (state == ARMED) || (state == CAPTURE);
    assign err        = t_err | abort_err;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a scaled-down VGA raster; two instances
// cover a left-side window and a window ending at the last active column.
module tb_vga_capture;

    localparam int HS = 4, HB = 4, HA = 24, HT = 36;
    localparam int VS = 2, VB = 2, VA = 12, VT = 18;
    localparam int W = 8, H = 6;
    localparam int XA = 2,  YA = 1;
    localparam int XB = 16, YB = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [11:0] d = '0;
    logic        arm = 1'b0;
    logic        locked_a, busy_a, done_a, err_a;
    logic        locked_b, busy_b, done_b, err_b;

    logic [20:0] q_a[$];
    logic [20:0] q_b[$];
    int n_checks = 0, n_fail = 0;
    int n_done_a = 0, n_done_b = 0, n_err_a = 0, n_err_b = 0;

    vga_capture_if #(.ADDR_W(15)) bus_a ();
    vga_capture_if #(.ADDR_W(15)) bus_b ();

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .X_OFF(XA), .Y_OFF(YA), .IMG_W(W), .IMG_H(H), .ADDR_W(15)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .VGA_HSYNC(hsync), .VGA_VSYNC(vsync), .VGA_D(d), .arm(arm),
        .wr(bus_a), .locked(locked_a), .busy(busy_a),
        .frame_done(done_a), .err(err_a)
    );

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .X_OFF(XB), .Y_OFF(YB), .IMG_W(W), .IMG_H(H), .ADDR_W(15)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .VGA_HSYNC(hsync), .VGA_VSYNC(vsync), .VGA_D(d), .arm(arm),
        .wr(bus_b), .locked(locked_b), .busy(busy_b),
        .frame_done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pop and compare every write; a write with nothing expected meets an
    // all-ones entry no real write can match.
    always @(negedge clk) begin
        logic [20:0] ea, eb;
        if (bus_a.wr_en) begin
            if (q_a.size() > 0) ea = q_a.pop_front();
            else ea = '1;
            check("wr_a", 32'({bus_a.wr_addr, bus_a.wr_data}), 32'(ea));
        end
        if (bus_b.wr_en) begin
            if (q_b.size() > 0) eb = q_b.pop_front();
            else eb = '1;
            check("wr_b", 32'({bus_b.wr_addr, bus_b.wr_data}), 32'(eb));
        end
        if (done_a) n_done_a++;
        if (done_b) n_done_b++;
        if (err_a)  n_err_a++;
        if (err_b)  n_err_b++;
    end

    // One frame: every pixel takes a pix_en clk plus an idle clk. Expected
    // writes are queued as window pixels are driven (only up to bad_line, and
    // only before rst_line, where reset is pulsed once).
    task automatic drive_frame(input bit cap, input int bad_line, input int rst_line);
        int an, bn, xx, yy, len;
        logic [3:0]  xl, yl;
        logic [11:0] pd;
        an = 0;
        bn = 0;
        for (int v = 0; v < VT; v++) begin
            len = (v == bad_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                xx = h - (HS + HB);
                yy = v - (VS + VB);
                xl = xx[3:0];
                yl = yy[3:0];
                pd = (xx >= 0 && xx < HA && yy >= 0 && yy < VA) ? {xl, yl, 4'h5} : 12'h000;
                @(negedge clk);
                pix_en = 1'b1;
                hsync  = (h >= HS);
                vsync  = (v >= VS);
                d      = pd;
                if (cap && (bad_line < 0 || v <= bad_line) && (rst_line < 0 || v < rst_line)) begin
                    if (xx >= XA && xx < XA + W && yy >= YA && yy < YA + H) begin
                        q_a.push_back({15'(an), pd[11:10], pd[7:6], pd[3:2]});
                        an++;
                    end
                    if (xx >= XB && xx < XB + W && yy >= YB && yy < YB + H) begin
                        q_b.push_back({15'(bn), pd[11:10], pd[7:6], pd[3:2]});
                        bn++;
                    end
                end
                @(negedge clk);
                pix_en = 1'b0;
                if (v == rst_line && h == 0) begin
                    reset = 1'b1;
                    @(negedge clk);
                    check("rst_mid_a", 32'({bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data,
                                            locked_a, busy_a, done_a, err_a}), 32'd0);
                    check("rst_mid_b", 32'({bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data,
                                            locked_b, busy_b, done_b, err_b}), 32'd0);
                    reset = 1'b0;
                end
            end
        end
    endtask

    task automatic frame_end_checks(input string tag, input int exp_done);
        check({tag, "_done_a"}, 32'(n_done_a), 32'(exp_done));
        check({tag, "_done_b"}, 32'(n_done_b), 32'(exp_done));
        check({tag, "_q_a"}, 32'(q_a.size()), 32'd0);
        check({tag, "_q_b"}, 32'(q_b.size()), 32'd0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_a", 32'({bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data,
                            locked_a, busy_a, done_a, err_a}), 32'd0);
        check("rst_b", 32'({bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data,
                            locked_b, busy_b, done_b, err_b}), 32'd0);
        reset = 1'b0;
        arm   = 1'b1;
        repeat (8) begin
            @(negedge clk); pix_en = 1'b1;
            @(negedge clk); pix_en = 1'b0;
        end

        // Cold start: lines lock within frame 0, frame lock at frame 1 start.
        drive_frame(1'b0, -1, -1);
        check("cold_lock_a", 32'(locked_a), 32'd0);
        check("cold_busy_a", 32'(busy_a), 32'd1);
        frame_end_checks("f0", 0);

        // Frames 1-3 captured back to back; arm drops while ARMED before 3.
        drive_frame(1'b1, -1, -1);
        check("f1_lock_a", 32'(locked_a), 32'd1);
        check("f1_lock_b", 32'(locked_b), 32'd1);
        check("f1_addr_hold_a", 32'(bus_a.wr_addr), 32'(W * H - 1));
        check("f1_addr_hold_b", 32'(bus_b.wr_addr), 32'(W * H - 1));
        frame_end_checks("f1", 1);
        drive_frame(1'b1, -1, -1);
        arm = 1'b0;
        frame_end_checks("f2", 2);
        drive_frame(1'b1, -1, -1);
        frame_end_checks("f3", 3);

        // Unarmed frame: no writes at all.
        drive_frame(1'b0, -1, -1);
        frame_end_checks("f4", 3);
        check("f4_busy_a", 32'(busy_a), 32'd0);
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        check("arm_busy_a", 32'(busy_a), 32'd1);

        // 35-pixel line inside the window: abort, single err, lock regained.
        drive_frame(1'b1, 7, -1);
        frame_end_checks("f5", 3);
        check("f5_err_a", 32'(n_err_a), 32'd1);
        check("f5_err_b", 32'(n_err_b), 32'd1);
        check("f5_busy_a", 32'(busy_a), 32'd0);
        check("f5_relock_a", 32'(locked_a), 32'd1);

        // Next capture restarts at address 0.
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        drive_frame(1'b1, -1, -1);
        frame_end_checks("f6", 4);

        // Reset mid-capture, arm held: relock takes a full frame.
        arm = 1'b1;
        drive_frame(1'b1, -1, 7);
        frame_end_checks("f7", 4);
        drive_frame(1'b0, -1, -1);
        check("f8_lock_a", 32'(locked_a), 32'd0);
        check("f8_busy_a", 32'(busy_a), 32'd1);
        frame_end_checks("f8", 4);
        drive_frame(1'b1, -1, -1);
        arm = 1'b0;
        frame_end_checks("f9", 5);
        check("end_err_a", 32'(n_err_a), 32'd1);
        check("end_err_b", 32'(n_err_b), 32'd1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
